recon_ctrl: RTL and testbench
=============================

# recon_ctrl

Reconfiguration controller that sequences the swap of one reconfigurable region (the maximum core or any other core on the same producer/consumer ports with an intern_sync add-on). It accepts a swap request from software, quiesces the current module through the rc_reqn/rc_ackn handshake, and isolates the region. It then drives the configuration engine, resets the new module and releases the region. It sits between the processor-side control registers and the reconfigurable region's rc_reqn/rc_ackn, isolation and reset pins.

## Interface
Parameters:
- C_ACK_TIMEOUT, 256, cycles to wait for rc_ackn low before aborting (2..65535)
- C_RST_CYCLES, 4, cycles rm_rstn is held low after configuration (1..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- sw_req  in  1  swap request, sampled only in S_IDLE and S_FAIL
- sw_id  in  8  target module id, latched with sw_req
- sw_busy  out  1  high whenever state is not S_IDLE
- sw_done  out  1  one-cycle pulse, swap (or no-op) complete
- sw_err  out  1  one-cycle pulse, ack timeout or configuration error
- cur_id  out  8  id of the module currently loaded
- rc_reqn  out  1  active-low quiesce request to region
- rc_ackn  in  1  active-low acknowledge from region (module idle)
- isolate  out  1  high: region ports clamped by static isolation logic
- rm_rstn  out  1  active-low reset to the reconfigurable module
- cfg_req  out  1  level request to configuration engine
- cfg_id  out  8  id to load, stable while cfg_req high
- cfg_done  in  1  one-cycle pulse, load successful
- cfg_err  in  1  one-cycle pulse, load failed

## Operation
- States are S_IDLE, S_REQ, S_ISO, S_CFG, S_RST, S_REL and S_FAIL.
- S_IDLE
  - On sw_req: latch sw_id into tgt_id.
  - If sw_id == cur_id: stay in S_IDLE and pulse sw_done (no-op).
  - Otherwise go to S_REQ.
- S_REQ: rc_reqn=0 and the 16-bit ack counter increments.
  - rc_ackn==0 goes to S_ISO.
  - Counter == C_ACK_TIMEOUT-1 with rc_ackn==1 goes to S_IDLE and pulses sw_err. cur_id is unchanged and isolate is never raised.
  - rc_ackn==0 in the timeout cycle: the ack wins.
- S_ISO: exactly one cycle, isolate=1, then S_CFG.
- S_CFG: cfg_req=1 and cfg_id=tgt_id.
  - cfg_done goes to S_RST; cur_id<=tgt_id on the same edge.
  - cfg_err goes to S_FAIL and pulses sw_err.
  - Both high in the same cycle: cfg_err wins.
- S_RST: rm_rstn=0 for exactly C_RST_CYCLES cycles (down-counter), then S_REL.
- S_REL: rc_reqn=1 and isolate=0. Wait for rc_ackn==1, then go to S_IDLE and pulse sw_done.
- S_FAIL: isolate=1, rc_reqn=0, rm_rstn=0 and cur_id=8'hFF (unknown).
  - sw_req latches sw_id and goes straight to S_ISO; no quiesce is needed.
  - The sw_id==cur_id no-op check does not apply here.
- Output decode by state:
  - rc_reqn=0 in S_REQ, S_ISO, S_CFG, S_RST and S_FAIL.
  - isolate=1 in S_ISO, S_CFG, S_RST and S_FAIL.
  - rm_rstn=0 in S_RST and S_FAIL.
- sw_req while busy (any state other than S_IDLE/S_FAIL) is ignored, not queued.
- The ack counter clears on entry to S_REQ. The reset counter loads C_RST_CYCLES on entry to S_RST.

## Timing
- Reset values:
  - state=S_IDLE, cur_id=0 (module 0 loaded at power-up).
  - rc_reqn=1, isolate=0, rm_rstn=1, cfg_req=0, cfg_id=0.
  - sw_busy=0, sw_done=0, sw_err=0.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Swap latency:
  - sw_req sampled at edge 0 puts the FSM in S_REQ after edge 0, so rc_reqn falls in cycle 1.
  - With ack sampled at edge a: S_ISO is 1 cycle, S_CFG lasts until cfg_done, S_RST is C_RST_CYCLES, S_REL lasts until ack release.
  - sw_done is high in the first S_IDLE cycle.
- No-op latency: sw_done is high the cycle after sw_req, and sw_busy stays 0.
- sw_done and sw_err are never high in the same cycle.
- rstn asserted mid-swap returns all outputs to reset values immediately (asynchronous), and cur_id returns to 0.

## Test plan
- Normal swap: after reset, sw_req with sw_id=3, rc_ackn falls 5 cycles later, cfg_done 20 cycles after cfg_req.
  - rc_reqn low from cycle 1.
  - isolate high 1 cycle before cfg_req.
  - cfg_id=3.
  - rm_rstn low exactly 4 cycles.
  - sw_done single pulse.
  - cur_id=3.
- No-op: after reset, sw_req with sw_id=0 -> sw_done the next cycle; rc_reqn, isolate and cfg_req never change; sw_busy stays 0.
- Ack timeout: C_ACK_TIMEOUT=16, rc_ackn held 1 -> rc_reqn low exactly 16 cycles, then sw_err pulse, isolate never 1, cur_id unchanged. Repeat with ack in cycle 16: the swap proceeds.
- Configuration failure: cfg_err during S_CFG -> sw_err pulse; isolate=1, rm_rstn=0, cur_id=8'hFF held. Then sw_req with sw_id=5 -> cfg_req 2 cycles later with no ack wait; success gives cur_id=5 and sw_done.
- Simultaneous and ignored events:
  - cfg_done and cfg_err together -> S_FAIL path.
  - sw_req with sw_id=7 during S_CFG of id 3 -> ignored; final cur_id=3 and only one sw_done.
- Reset mid-operation: rstn low during S_RST -> rc_reqn=1, isolate=0, rm_rstn=1, cfg_req=0, cur_id=0 without waiting for clk. After release, a normal swap completes.

Source files
------------

// File: rtl/recon_ctrl.sv
// ---------------------------------------------------------------------------
// recon_ctrl
//
// Sequences the swap of one reconfigurable region. A software swap request
// quiesces the running module (rc_reqn/rc_ackn handshake), clamps the region
// with the static isolation logic, asks the configuration engine to load the
// new module, holds the new module in reset for a fixed number of cycles and
// finally releases the region.
//
// Ports:
//   clk, rstn         system clock, asynchronous active-low reset
//   sw_req, sw_id     swap request and target module id (software side)
//   sw_busy           high whenever the controller is not idle
//   sw_done, sw_err   one-cycle completion / failure pulses
//   cur_id            id of the module currently loaded (8'hFF = unknown)
//   rc_reqn, rc_ackn  active-low quiesce request / acknowledge with region
//   isolate           high while region ports are clamped
//   rm_rstn           active-low reset to the reconfigurable module
//   cfg_req, cfg_id   level request and id to the configuration engine
//   cfg_done, cfg_err one-cycle result pulses from the configuration engine
// ---------------------------------------------------------------------------
module recon_ctrl #(
    parameter int C_ACK_TIMEOUT = 256,
    parameter int C_RST_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sw_req,
    input  logic [7:0] sw_id,
    output logic       sw_busy,
    output logic       sw_done,
    output logic       sw_err,
    output logic [7:0] cur_id,
    output logic       rc_reqn,
    input  logic       rc_ackn,
    output logic       isolate,
    output logic       rm_rstn,
    output logic       cfg_req,
    output logic [7:0] cfg_id,
    input  logic       cfg_done,
    input  logic       cfg_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_ISO  = 3'd2;
    localparam logic [2:0] S_CFG  = 3'd3;
    localparam logic [2:0] S_RST  = 3'd4;
    localparam logic [2:0] S_REL  = 3'd5;
    localparam logic [2:0] S_FAIL = 3'd6;

    localparam logic [15:0] ACK_LAST = 16'(C_ACK_TIMEOUT - 1);
    localparam logic [7:0]  RST_LOAD = 8'(C_RST_CYCLES);

    logic [2:0]  state;
    logic [7:0]  tgt_id;
    logic [15:0] ack_cnt;
    logic [7:0]  rst_cnt;

    // Main sequencer. sw_done/sw_err are registered pulses so they appear in
    // the first cycle of the state that follows the decision. A failed load
    // leaves the region content unknown, hence cur_id is forced to 8'hFF.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            tgt_id  <= 8'h00;
            cur_id  <= 8'h00;
            ack_cnt <= 16'h0000;
            rst_cnt <= 8'h00;
            sw_done <= 1'b0;
            sw_err  <= 1'b0;
        end else begin
            sw_done <= 1'b0;
            sw_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sw_req) begin
                        tgt_id <= sw_id;
                        if (sw_id == cur_id) begin
                            sw_done <= 1'b1;
                        end else begin
                            state   <= S_REQ;
                            ack_cnt <= 16'h0000;
                        end
                    end
                end
                S_REQ: begin
                    // An ack arriving in the timeout cycle still wins.
                    if (!rc_ackn) begin
                        state <= S_ISO;
                    end else if (ack_cnt == ACK_LAST) begin
                        state  <= S_IDLE;
                        sw_err <= 1'b1;
                    end else begin
                        ack_cnt <= ack_cnt + 16'd1;
                    end
                end
                S_ISO: begin
                    state <= S_CFG;
                end
                S_CFG: begin
                    if (cfg_err) begin
                        state  <= S_FAIL;
                        sw_err <= 1'b1;
                        cur_id <= 8'hFF;
                    end else if (cfg_done) begin
                        state   <= S_RST;
                        cur_id  <= tgt_id;
                        rst_cnt <= RST_LOAD;
                    end
                end
                S_RST: begin
                    if (rst_cnt == 8'd1) begin
                        state <= S_REL;
                    end else begin
                        rst_cnt <= rst_cnt - 8'd1;
                    end
                end
                S_REL: begin
                    if (rc_ackn) begin
                        state   <= S_IDLE;
                        sw_done <= 1'b1;
                    end
                end
                S_FAIL: begin
                    // Region is already quiesced and isolated, so a retry goes
                    // straight to isolation without another handshake.
                    if (sw_req) begin
                        tgt_id <= sw_id;
                        state  <= S_ISO;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Region-side outputs are pure decodes of the registered state.
    always_comb begin
        sw_busy = (state != S_IDLE);
        rc_reqn = !((state == S_REQ) || (state == S_ISO) || (state == S_CFG) ||
                    (state == S_RST) || (state == S_FAIL));
        isolate = (state == S_ISO) || (state == S_CFG) || (state == S_RST) ||
                  (state == S_FAIL);
        rm_rstn = !((state == S_RST) || (state == S_FAIL));
        cfg_req = (state == S_CFG);
        cfg_id  = cfg_req ? tgt_id : 8'h00;
    end

endmodule

// File: tb/tb_recon_ctrl.sv
// ---------------------------------------------------------------------------
// tb_recon_ctrl
//
// Directed testbench for recon_ctrl with a short ack timeout (16 cycles) and
// the default 4-cycle module reset. Inputs are driven and outputs sampled
// 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_recon_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       sw_req;
    logic [7:0] sw_id;
    logic       sw_busy;
    logic       sw_done;
    logic       sw_err;
    logic [7:0] cur_id;
    logic       rc_reqn;
    logic       rc_ackn;
    logic       isolate;
    logic       rm_rstn;
    logic       cfg_req;
    logic [7:0] cfg_id;
    logic       cfg_done;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;

    recon_ctrl #(
        .C_ACK_TIMEOUT(16),
        .C_RST_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sw_req  (sw_req),
        .sw_id   (sw_id),
        .sw_busy (sw_busy),
        .sw_done (sw_done),
        .sw_err  (sw_err),
        .cur_id  (cur_id),
        .rc_reqn (rc_reqn),
        .rc_ackn (rc_ackn),
        .isolate (isolate),
        .rm_rstn (rm_rstn),
        .cfg_req (cfg_req),
        .cfg_id  (cfg_id),
        .cfg_done(cfg_done),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        checks++;
        assert (observed == expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    initial begin
        int  n;
        logic iso_seen;

        rstn     = 1'b0;
        sw_req   = 1'b0;
        sw_id    = 8'h00;
        rc_ackn  = 1'b1;
        cfg_done = 1'b0;
        cfg_err  = 1'b0;

        // Reset values
        repeat (3) tick();
        check1("rst_rc_reqn", rc_reqn, 1'b1);
        check1("rst_isolate", isolate, 1'b0);
        check1("rst_rm_rstn", rm_rstn, 1'b1);
        check1("rst_cfg_req", cfg_req, 1'b0);
        check8("rst_cfg_id", cfg_id, 8'h00);
        check1("rst_busy", sw_busy, 1'b0);
        check1("rst_done", sw_done, 1'b0);
        check1("rst_err", sw_err, 1'b0);
        check8("rst_cur_id", cur_id, 8'h00);
        rstn = 1'b1;
        tick();

        // No-op swap to the already loaded module 0
        sw_req = 1'b1;
        sw_id  = 8'h00;
        tick();
        sw_req = 1'b0;
        check1("noop_done", sw_done, 1'b1);
        check1("noop_busy", sw_busy, 1'b0);
        check1("noop_rc_reqn", rc_reqn, 1'b1);
        check1("noop_isolate", isolate, 1'b0);
        check1("noop_cfg_req", cfg_req, 1'b0);
        tick();
        check1("noop_done_clr", sw_done, 1'b0);
        check1("noop_busy2", sw_busy, 1'b0);

        // Normal swap to id 3, ack 5 cycles later, with an ignored request
        sw_req = 1'b1;
        sw_id  = 8'h03;
        tick();
        sw_req = 1'b0;
        check1("sw3_rc_reqn_c1", rc_reqn, 1'b0);
        check1("sw3_busy", sw_busy, 1'b1);
        check1("sw3_iso_req", isolate, 1'b0);
        repeat (4) tick();
        check1("sw3_rc_reqn_c5", rc_reqn, 1'b0);
        rc_ackn = 1'b0;
        tick();
        check1("sw3_iso", isolate, 1'b1);
        check1("sw3_iso_nocfg", cfg_req, 1'b0);
        tick();
        check1("sw3_cfg_req", cfg_req, 1'b1);
        check8("sw3_cfg_id", cfg_id, 8'h03);
        sw_req = 1'b1;
        sw_id  = 8'h07;
        tick();
        sw_req = 1'b0;
        check1("ign_cfg_req", cfg_req, 1'b1);
        check8("ign_cfg_id", cfg_id, 8'h03);
        repeat (18) tick();
        check8("sw3_cur_before", cur_id, 8'h00);
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        check8("sw3_cur_id", cur_id, 8'h03);
        check1("sw3_cfg_req_off", cfg_req, 1'b0);
        n = 0;
        while (rm_rstn === 1'b0 && n < 20) begin
            n++;
            tick();
        end
        check_int("sw3_rst_len", n, 4);
        check1("sw3_rel_rc_reqn", rc_reqn, 1'b1);
        check1("sw3_rel_isolate", isolate, 1'b0);
        check1("sw3_rel_done", sw_done, 1'b0);
        rc_ackn = 1'b1;
        tick();
        check1("sw3_done", sw_done, 1'b1);
        check1("sw3_idle", sw_busy, 1'b0);
        tick();
        check1("sw3_done_once", sw_done, 1'b0);
        check8("sw3_cur_final", cur_id, 8'h03);

        // Ack timeout: rc_ackn held high
        sw_req = 1'b1;
        sw_id  = 8'h09;
        tick();
        sw_req = 1'b0;
        n = 0;
        iso_seen = 1'b0;
        while (rc_reqn === 1'b0 && n < 40) begin
            if (isolate !== 1'b0) iso_seen = 1'b1;
            n++;
            tick();
        end
        check_int("to_reqn_len", n, 16);
        check1("to_err", sw_err, 1'b1);
        check1("to_no_done", sw_done, 1'b0);
        check1("to_iso_seen", iso_seen, 1'b0);
        check8("to_cur_id", cur_id, 8'h03);
        check1("to_idle", sw_busy, 1'b0);
        tick();
        check1("to_err_clr", sw_err, 1'b0);

        // Ack in the timeout cycle wins, then simultaneous cfg_done/cfg_err
        sw_req = 1'b1;
        sw_id  = 8'h09;
        tick();
        sw_req = 1'b0;
        repeat (15) tick();
        check1("late_reqn", rc_reqn, 1'b0);
        rc_ackn = 1'b0;
        tick();
        check1("late_iso", isolate, 1'b1);
        check1("late_no_err", sw_err, 1'b0);
        tick();
        check1("late_cfg_req", cfg_req, 1'b1);
        cfg_done = 1'b1;
        cfg_err  = 1'b1;
        tick();
        cfg_done = 1'b0;
        cfg_err  = 1'b0;
        check1("both_err", sw_err, 1'b1);
        check1("both_no_done", sw_done, 1'b0);
        check8("both_cur_id", cur_id, 8'hFF);
        check1("fail_isolate", isolate, 1'b1);
        check1("fail_rm_rstn", rm_rstn, 1'b0);
        check1("fail_rc_reqn", rc_reqn, 1'b0);
        check1("fail_busy", sw_busy, 1'b1);
        tick();
        check1("fail_err_clr", sw_err, 1'b0);
        check8("fail_cur_hold", cur_id, 8'hFF);

        // Plain cfg_err from a retry
        sw_req = 1'b1;
        sw_id  = 8'h04;
        tick();
        sw_req = 1'b0;
        tick();
        check8("retry4_cfg_id", cfg_id, 8'h04);
        cfg_err = 1'b1;
        tick();
        cfg_err = 1'b0;
        check1("cerr_err", sw_err, 1'b1);
        check8("cerr_cur_id", cur_id, 8'hFF);
        check1("cerr_isolate", isolate, 1'b1);

        // Recovery from S_FAIL: cfg_req two cycles after sw_req, no ack wait
        sw_req = 1'b1;
        sw_id  = 8'h05;
        tick();
        sw_req = 1'b0;
        check1("rec_iso", isolate, 1'b1);
        check1("rec_no_cfg", cfg_req, 1'b0);
        tick();
        check1("rec_cfg_req", cfg_req, 1'b1);
        check8("rec_cfg_id", cfg_id, 8'h05);
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        check8("rec_cur_id", cur_id, 8'h05);
        check1("rec_rm_rstn", rm_rstn, 1'b0);
        repeat (4) tick();
        check1("rec_rel_rm_rstn", rm_rstn, 1'b1);
        check1("rec_rel_rc_reqn", rc_reqn, 1'b1);
        rc_ackn = 1'b1;
        tick();
        check1("rec_done", sw_done, 1'b1);
        check1("rec_no_err", sw_err, 1'b0);
        tick();

        // Asynchronous reset during S_RST
        sw_req = 1'b1;
        sw_id  = 8'h06;
        tick();
        sw_req  = 1'b0;
        rc_ackn = 1'b0;
        tick();
        tick();
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        check1("mid_rm_rstn", rm_rstn, 1'b0);
        check8("mid_cur_id", cur_id, 8'h06);
        #2;
        rstn = 1'b0;
        #1;
        check1("arst_rc_reqn", rc_reqn, 1'b1);
        check1("arst_isolate", isolate, 1'b0);
        check1("arst_rm_rstn", rm_rstn, 1'b1);
        check1("arst_cfg_req", cfg_req, 1'b0);
        check8("arst_cur_id", cur_id, 8'h00);
        check1("arst_busy", sw_busy, 1'b0);
        rc_ackn = 1'b1;
        tick();
        rstn = 1'b1;
        tick();

        // Normal swap after reset release
        sw_req = 1'b1;
        sw_id  = 8'h02;
        tick();
        sw_req  = 1'b0;
        rc_ackn = 1'b0;
        tick();
        tick();
        check8("post_cfg_id", cfg_id, 8'h02);
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        repeat (4) tick();
        rc_ackn = 1'b1;
        tick();
        check1("post_done", sw_done, 1'b1);
        check8("post_cur_id", cur_id, 8'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
